addr_latch_unit: RTL
====================

// Module: addr_latch_unit
// PURPOSE
//  Clocked, parametrised address latch for the 6502 core. Loads the address one byte lane at a
//  time from the 8-bit data bus. Supports whole-register increment and decrement.
//  Adds an 8-bit index (unsigned) or branch offset (signed) to the low byte, then applies a
//  deferred page-crossing fixup to the upper bytes one cycle later, as the 6502 does.
//  Sits between the data bus and the address bus mux; used for PC, effective address and pointer temps.
// PARAMETERS
//  NBYTES     2     byte lanes; register width W = 8*NBYTES (NBYTES >= 2)
//  RST_VAL    0     W-bit reset value of the register
//  FIX_DEFER  1     1: page carry/borrow applied in a FIXUP cycle; 0: applied in the same cycle
// PORTS
//  clk        in   1       core clock; all state updates on rising edge
//  rst_n      in   1       asynchronous active-low reset
//  data_in    in   8       byte from data bus
//  load_en    in   1       load data_in into every lane selected by load_sel
//  load_sel   in   NBYTES  lane select, bit i -> addr[8i+7:8i]
//  inc        in   1       addr <= addr + 1 (full width, wraps)
//  dec        in   1       addr <= addr - 1 (full width, wraps)
//  idx_add    in   1       add idx to the low byte
//  idx        in   8       index / offset value
//  idx_signed in   1       1: idx is a two's-complement offset; 0: idx is unsigned
//  addr       out  W       current register value
//  page_cross out  1       high for 1 cycle after an idx_add whose low-byte add left the page
//  busy       out  1       high while in FIXUP; upper bytes are not yet valid
// BEHAVIOUR
//  - Reset (async assert, sync-safe deassert): addr=RST_VAL, page_cross=0, busy=0, state=IDLE.
//  - States: IDLE, FIXUP. FIXUP only exists when FIX_DEFER=1.
//  - Priority in IDLE, at most one action per cycle: load_en > idx_add > inc > dec. Lower-priority requests are dropped, not queued.
//  - load: each lane with load_sel[i]=1 gets data_in; other lanes hold. load_sel=0 is a no-op.
//  - idx_add: lo' = (lo + idx) mod 256. Upper field U = addr[W-1:8].
//      carry  = unsigned 9-bit sum > 255 (idx_signed=0, or idx_signed=1 with idx[7]=0)
//      borrow = idx_signed=1 and idx[7]=1 and no 9-bit carry
//      Fixup delta d = +1 on carry, -1 on borrow, else 0.
//    FIX_DEFER=1: lo updates this cycle. If d!=0: page_cross=1, busy=1, go to FIXUP.
//      In FIXUP the next edge does U <= U+d (mod 2^(W-8)), clears busy, returns to IDLE.
//    FIX_DEFER=0: lo and U update on the same edge; page_cross=1 for one cycle; busy stays 0.
//  - page_cross is registered. It is high in exactly the cycle after the idx_add edge.
//  - FIXUP ignores load_en/inc/dec/idx_add. The core must not issue them while busy=1.
//    Assertion: no request while busy.
//  - inc/dec: full W-bit wrap. FF..FF+1 -> 0; 0-1 -> FF..FF. No flags.
//  - inc and dec together (neither load nor idx_add): inc wins. Assertion warns.
//  - Reset mid-FIXUP: the fixup is abandoned; all state returns to reset values.
//  - No combinational path from inputs to outputs. Every output is a flop.
// STRUCTURE
//  - Shared package cpu6502_pkg: state enum {ST_IDLE, ST_FIXUP}; localparam BYTE_W=8.
//  - No sub-module. Byte-lane load is a generate loop. The upper-field adder takes d in {-1,0,+1}.
//  - Replaces the old combinational, edge-triggered latch. All control inputs are now
//    synchronous enables sampled on clk.
// TESTING
//  1 reset: rst_n=0 mid-cycle -> addr=0000, busy=0, page_cross=0, without waiting for clk.
//  2 load lo=34, then hi=12 (sel=01, then 10) -> addr=1234. sel=11, data=AA -> addr=AAAA.
//  3 addr=12F0, idx_add idx=20 unsigned, FIX_DEFER=1:
//    cycle1 addr=1210 page_cross=1 busy=1; cycle2 addr=1310 busy=0.
//  4 addr=1205, idx=F0 signed (-16) -> 12F5, then 11F5 with page_cross pulse;
//    addr=1280, idx=10 signed -> 1290, no page_cross.
//  5 inc at FFFF -> 0000; dec at 0000 -> FFFF; load_en+inc same cycle -> load only.
//  6 rst_n low during FIXUP -> addr=0000, busy=0, state IDLE;
//    NBYTES=3, FIX_DEFER=0: 00FFFF +idx 01 -> 010000 in one cycle.

Source files
------------

// File: rtl/cpu6502_pkg.sv
// cpu6502_pkg: shared state encoding and byte width for 6502 core blocks
package cpu6502_pkg;
  localparam int BYTE_W = 8;
  typedef enum logic {ST_IDLE, ST_FIXUP} state_e;
endpackage

// File: rtl/addr_latch_unit.sv
// addr_latch_unit: byte-loadable address register with inc/dec and 6502-style indexed add with page fixup
module addr_latch_unit
  import cpu6502_pkg::*;
#(
  parameter int NBYTES = 2,
  parameter logic [8*NBYTES-1:0] RST_VAL = '0,
  parameter bit FIX_DEFER = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [7:0]            data_in,
  input  logic                  load_en,
  input  logic [NBYTES-1:0]     load_sel,
  input  logic                  inc,
  input  logic                  dec,
  input  logic                  idx_add,
  input  logic [7:0]            idx,
  input  logic                  idx_signed,
  output logic [8*NBYTES-1:0]   addr,
  output logic                  page_cross,
  output logic                  busy
);
  localparam int W = BYTE_W * NBYTES;
  localparam int UW = W - BYTE_W;
  state_e state_q, state_d;
  logic [W-1:0] addr_q, addr_d, load_val;
  logic pc_q, pc_d, busy_q, busy_d, neg_q, neg_d;
  logic [BYTE_W:0] sum;
  logic carry, borrow, fix_neg;
  logic [UW-1:0] up_fix;
  genvar i;
  for (i = 0; i < NBYTES; i++) begin : g_lane
    assign load_val[BYTE_W*i +: BYTE_W] = load_sel[i] ? data_in : addr_q[BYTE_W*i +: BYTE_W];
  end
  assign sum = {1'b0, addr_q[BYTE_W-1:0]} + {1'b0, idx};
  assign carry = sum[BYTE_W] && !(idx_signed && idx[BYTE_W-1]);
  assign borrow = idx_signed && idx[BYTE_W-1] && !sum[BYTE_W];
  assign fix_neg = (state_q == ST_FIXUP) ? neg_q : borrow;
  assign up_fix = addr_q[W-1:BYTE_W] + (fix_neg ? {UW{1'b1}} : UW'(1));
  always_comb begin
    addr_d = addr_q;
    state_d = ST_IDLE;
    pc_d = 1'b0;
    busy_d = 1'b0;
    neg_d = neg_q;
    if (state_q == ST_FIXUP) addr_d = {up_fix, addr_q[BYTE_W-1:0]};
    else if (load_en) addr_d = load_val;
    else if (idx_add) begin
      pc_d = carry || borrow;
      neg_d = borrow;
      addr_d = {(FIX_DEFER || !pc_d) ? addr_q[W-1:BYTE_W] : up_fix, sum[BYTE_W-1:0]};
      state_d = (FIX_DEFER && pc_d) ? ST_FIXUP : ST_IDLE;
      busy_d = FIX_DEFER && pc_d;
    end
    else if (inc) addr_d = addr_q + W'(1);
    else if (dec) addr_d = addr_q - W'(1);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      addr_q <= RST_VAL;
      pc_q <= 1'b0;
      busy_q <= 1'b0;
      neg_q <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q <= addr_d;
      pc_q <= pc_d;
      busy_q <= busy_d;
      neg_q <= neg_d;
    end
  end
  assign addr = addr_q;
  assign page_cross = pc_q;
  assign busy = busy_q;
  a_no_req_busy: assert property (@(posedge clk) disable iff (!rst_n)
    busy_q |-> !(load_en || inc || dec || idx_add)) else $error("request issued while busy");
  a_inc_dec: assert property (@(posedge clk) disable iff (!rst_n)
    !(inc && dec && !load_en && !idx_add && !busy_q)) else $warning("inc and dec together, inc taken");
endmodule
